// File: rtl/archer_arrow_ctl.sv
// Arrow projectile controller: spawns on a fresh draw edge, flies per frame, retires, reloads.
// Optional ballistic drop enabled with `define ARCHER_ARROW_GRAVITY_EN.
module archer_arrow_ctl #(
    parameter int ARROW_SPEED     = 8,
    parameter int MAX_RANGE       = 400,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int SCREEN_W        = 1024,
    parameter int SCREEN_H        = 768,
    parameter int ARROW_W         = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        draw_weapon,
    input  logic        flip_hor_archer,
    input  logic [11:0] pos_x_archer_offset,
    input  logic [11:0] pos_y_archer_offset,
    input  logic        arrow_hit,
    output logic        arrow_active,
    output logic [11:0] arrow_x,
    output logic [11:0] arrow_y,
    output logic        arrow_dir,
    output logic        arrow_fired,
    output logic        reload_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLIGHT = 2'd1;
    localparam logic [1:0] S_COOL   = 2'd2;

    localparam logic [12:0] SPD13     = 13'(ARROW_SPEED);
    localparam logic [11:0] SPD12     = 12'(ARROW_SPEED);
    localparam logic [12:0] RIGHT_LIM = 13'(SCREEN_W - ARROW_W);
    localparam logic [12:0] RANGE13   = 13'(MAX_RANGE);
    localparam logic [15:0] CD_INIT   = 16'(COOLDOWN_FRAMES);
    localparam logic        CD_ZERO   = (COOLDOWN_FRAMES == 0);

    logic [1:0]  state_q, state_d;
    logic        draw_q;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        dir_q, dir_d;
    logic        fired_q, fired_d;
    logic [11:0] dist_q, dist_d;
    logic [15:0] cd_q, cd_d;

    logic shot_req;
    logic at_right;
    logic at_left;
    logic out_range;
    logic off_screen;
    logic retire;

`ifdef ARCHER_ARROW_GRAVITY_EN
    localparam logic [12:0] SCREEN_H13 = 13'(SCREEN_H);
    logic [3:0] vy_q, vy_d;
`endif

    assign shot_req  = draw_weapon & ~draw_q;
    assign at_right  = ~dir_q & (({1'b0, x_q} + SPD13) > RIGHT_LIM);
    assign at_left   = dir_q & ({1'b0, x_q} < SPD13);
    assign out_range = ({1'b0, dist_q} + SPD13) >= RANGE13;

`ifdef ARCHER_ARROW_GRAVITY_EN
    assign off_screen = ({1'b0, y_q} + {9'd0, vy_q}) >= SCREEN_H13;
`else
    assign off_screen = 1'b0;
`endif

    // A hit outranks a simultaneous frame tick, so the arrow never moves on it.
    assign retire = arrow_hit |
                    (frame_tick & (at_right | at_left | out_range | off_screen));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        fired_d = 1'b0;
        dist_d  = dist_q;
        cd_d    = cd_q;
`ifdef ARCHER_ARROW_GRAVITY_EN
        vy_d    = vy_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (shot_req) begin
                    state_d = S_FLIGHT;
                    x_d     = pos_x_archer_offset;
                    y_d     = pos_y_archer_offset;
                    dir_d   = flip_hor_archer;
                    fired_d = 1'b1;
                    dist_d  = 12'd0;
`ifdef ARCHER_ARROW_GRAVITY_EN
                    vy_d    = 4'd0;
`endif
                end
            end
            S_FLIGHT: begin
                if (retire) begin
                    state_d = CD_ZERO ? S_IDLE : S_COOL;
                    cd_d    = CD_INIT;
                end else if (frame_tick) begin
                    x_d    = dir_q ? (x_q - SPD12) : (x_q + SPD12);
                    dist_d = dist_q + SPD12;
`ifdef ARCHER_ARROW_GRAVITY_EN
                    y_d  = y_q + {8'd0, vy_q};
                    vy_d = (vy_q >= 4'd8) ? 4'd8 : (vy_q + 4'd1);
`endif
                end
            end
            S_COOL: begin
                if (cd_q == 16'd0) begin
                    state_d = S_IDLE;
                end else if (frame_tick) begin
                    cd_d = cd_q - 16'd1;
                    if (cd_q == 16'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            draw_q  <= 1'b0;
            x_q     <= 12'd0;
            y_q     <= 12'd0;
            dir_q   <= 1'b0;
            fired_q <= 1'b0;
            dist_q  <= 12'd0;
            cd_q    <= 16'd0;
`ifdef ARCHER_ARROW_GRAVITY_EN
            vy_q    <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            draw_q  <= draw_weapon;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            fired_q <= fired_d;
            dist_q  <= dist_d;
            cd_q    <= cd_d;
`ifdef ARCHER_ARROW_GRAVITY_EN
            vy_q    <= vy_d;
`endif
        end
    end

    assign arrow_active = (state_q == S_FLIGHT);
    assign reload_busy  = (state_q == S_COOL);
    assign arrow_x      = x_q;
    assign arrow_y      = y_q;
    assign arrow_dir    = dir_q;
    assign arrow_fired  = fired_q;

endmodule

// File: doc/archer_arrow_ctl.md
Name: archer_arrow_ctl

Overview:
Projectile stage directly downstream of the archer weapon controller. It consumes the weapon controller's outputs: draw_weapon, flip_hor_archer and the offset bow position. On each new shot it spawns one arrow at the bow position and moves it horizontally once per video frame. It retires the arrow on a hit, at maximum range or at the screen edge, then enforces a reload cooldown. Its outputs feed the arrow sprite draw stage and the enemy collision checker.

Parameters:
ARROW_SPEED, 8, pixels moved per frame_tick
MAX_RANGE, 400, pixels travelled before the arrow is retired
COOLDOWN_FRAMES, 30, frame_ticks after retirement before the next shot is accepted
SCREEN_W, 1024, visible width in pixels
SCREEN_H, 768, visible height in pixels (used only by the optional feature)
ARROW_W, 24, arrow sprite width in pixels

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame
draw_weapon  in  1  high while the weapon is drawn; a rising edge requests a shot
flip_hor_archer  in  1  facing: 0 = right, 1 = left
pos_x_archer_offset  in  12  bow x position, unsigned pixels
pos_y_archer_offset  in  12  bow y position, unsigned pixels
arrow_hit  in  1  collision checker reports the arrow hit an enemy
arrow_active  out  1  arrow is in flight; drives sprite enable
arrow_x  out  12  arrow x position
arrow_y  out  12  arrow y position
arrow_dir  out  1  flight direction latched at spawn (0 = right, 1 = left)
arrow_fired  out  1  one-cycle pulse at spawn, for the sound/score logic
reload_busy  out  1  high during COOLDOWN

Behaviour:
- Reset: rst and clk are as declared in Ports; reset is synchronous and active-high.
- All outputs reset to 0. State resets to IDLE. The internal draw_weapon delay register resets to 0.
- Shot request: shot_req = draw_weapon & ~draw_weapon_d, where draw_weapon_d is a one-cycle registered copy of draw_weapon.
- FSM states: IDLE, FLIGHT, COOLDOWN.
- IDLE to FLIGHT: when shot_req is seen at cycle N, at N+1 the block drives:
  - arrow_active=1
  - arrow_x and arrow_y = pos_x_archer_offset and pos_y_archer_offset as sampled at N
  - arrow_dir = flip_hor_archer as sampled at N
  - arrow_fired=1 for that single cycle
  - distance counter (12 bits) = 0
- FLIGHT, on each frame_tick, checks in priority order:
  1. Right edge: dir=0 and arrow_x + ARROW_SPEED > SCREEN_W - ARROW_W. Retire the arrow.
  2. Left edge: dir=1 and arrow_x < ARROW_SPEED. Retire the arrow (no unsigned wrap).
  3. Range: distance + ARROW_SPEED >= MAX_RANGE. Retire the arrow.
  4. Otherwise move: arrow_x += ARROW_SPEED (dir=0) or -= ARROW_SPEED (dir=1), and distance += ARROW_SPEED.
  - Compute every comparison at 13 bits so no overflow occurs.
- arrow_hit during FLIGHT retires the arrow on the next cycle. If arrow_hit and frame_tick arrive in the same cycle, arrow_hit wins and no move happens.
- Retire: arrow_active=0 on the next cycle and state goes to COOLDOWN. arrow_x and arrow_y hold their last values. The cooldown counter is loaded with COOLDOWN_FRAMES.
- COOLDOWN: decrement the counter on each frame_tick; reload_busy=1. When the counter reaches 0, go to IDLE.
- COOLDOWN_FRAMES=0: the block returns to IDLE on the cycle after retirement.
- shot_req outside IDLE is dropped, not queued. A held draw_weapon never re-triggers; only a fresh rising edge fires.
- arrow_hit outside FLIGHT is ignored.
- Input position changes during FLIGHT do not affect the arrow.
- rst mid-flight: the arrow vanishes immediately, state goes to IDLE, and the cooldown is cleared.

Optional Feature:
- Macro: ARCHER_ARROW_GRAVITY_EN.
- Defined:
  - An internal 4-bit vertical velocity vy is set to 0 at spawn.
  - On each moving frame_tick, arrow_y += vy, then vy increments, saturating at 8.
  - An extra retire condition, checked after condition 3: arrow_y + vy >= SCREEN_H.
- Undefined: arrow_y stays constant for the whole flight and the vy logic is absent.

Test Plan:
- Spawn right: reset, offset=(100,200), flip=0, raise draw_weapon at cycle N. At N+1: arrow_active=1, arrow_x=100, arrow_y=200, dir=0, arrow_fired pulses exactly one cycle. After 3 frame_ticks: arrow_x=124.
- Range limit: spawn at x=100, dir=0, defaults. Movement stops at x=492 (distance 392). The next frame_tick clears arrow_active; reload_busy=1 for 30 frame_ticks, then IDLE.
- Left edge: spawn at x=20, flip=1. Ticks give x=12, then x=4, then the arrow retires (4 < 8). arrow_x never wraps above 1023.
- Hit priority: in FLIGHT, assert arrow_hit and frame_tick in the same cycle. arrow_active=0 next cycle and arrow_x is unchanged.
- Retrigger rules: hold draw_weapon high through the whole flight and cooldown; no second spawn occurs. Toggle draw_weapon during COOLDOWN; no spawn and no queued shot. Toggle in IDLE; a spawn occurs.
- Reset mid-flight: rst during FLIGHT. All outputs are 0 next cycle. An immediate new rising edge spawns with no cooldown wait.
